// File: rtl/vproc_mem_bridge.sv
// Request-queue bridge between a vector-processor memory port and a single-outstanding
// storage controller: FIFO-buffered requests, one access at a time, in-order responses.
module vproc_mem_bridge #(
  parameter int MEM_W          = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_i,
  output logic               mem_gnt_o,
  input  logic               mem_we_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  output logic               mem_err_o,
  output logic               sc_access_o,
  output logic               sc_is_writing_o,
  output logic [31:0]        sc_addr_o,
  output logic [31:0]        sc_d_in_o,
  output logic [MEM_W/8-1:0] sc_be_o,
  input  logic [31:0]        sc_d_out_i,
  input  logic               sc_out_valid_i
);

  localparam int BE_W  = MEM_W / 8;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e state_q, state_d;

  logic             fifo_we_q    [FIFO_DEPTH];
  logic [31:0]      fifo_addr_q  [FIFO_DEPTH];
  logic [BE_W-1:0]  fifo_be_q    [FIFO_DEPTH];
  logic [MEM_W-1:0] fifo_wdata_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;

  logic             full, empty, push, pop, gnt;
  logic             head_we;
  logic [31:0]      head_addr;
  logic [BE_W-1:0]  head_be;
  logic [MEM_W-1:0] head_wdata;

  logic             hold_we_q, hold_we_d;
  logic [31:0]      hold_addr_q, hold_addr_d;
  logic [BE_W-1:0]  hold_be_q, hold_be_d;
  logic [MEM_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MEM_W-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign pop   = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full queue can still take a request.
  assign gnt   = !full || pop;
  assign push  = mem_req_i && gnt;

  assign head_we    = fifo_we_q[rptr_q];
  assign head_addr  = fifo_addr_q[rptr_q];
  assign head_be    = fifo_be_q[rptr_q];
  assign head_wdata = fifo_wdata_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wptr_q]    <= mem_we_i;
      fifo_addr_q[wptr_q]  <= mem_addr_i;
      fifo_be_q[wptr_q]    <= mem_be_i;
      fifo_wdata_q[wptr_q] <= mem_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_be_d    = hold_be_q;
    hold_wdata_d = hold_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          hold_we_d    = head_we;
          hold_addr_d  = head_addr;
          hold_be_d    = head_be;
          hold_wdata_d = head_wdata;
          cnt_d        = '0;
          // Misaligned requests never reach the controller.
          if (head_addr[1:0] != 2'b00) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (sc_out_valid_i) begin
          state_d = RESP;
          rdata_d = hold_we_q ? '0 : MEM_W'(sc_d_out_i);
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_be_q    <= hold_be_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

  assign mem_gnt_o       = gnt;
  assign mem_rvalid_o    = (state_q == RESP);
  assign mem_rdata_o     = mem_rvalid_o ? rdata_q : '0;
  assign mem_err_o       = mem_rvalid_o && err_q;
  assign sc_access_o     = (state_q == ISSUE);
  assign sc_is_writing_o = hold_we_q;
  assign sc_addr_o       = hold_addr_q;
  assign sc_d_in_o       = 32'(hold_wdata_q);
  assign sc_be_o         = hold_be_q;

endmodule

// File: tb/tb_vproc_mem_bridge.sv
// Directed bench for vproc_mem_bridge: a scripted storage controller answers accesses,
// a monitor collects responses, and each scenario checks against hand-derived values.
module tb_vproc_mem_bridge;

  localparam int MEM_W = 32;
  localparam int BE_W  = MEM_W / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             mem_req_i = 1'b0;
  logic             mem_gnt_o;
  logic             mem_we_i = 1'b0;
  logic [31:0]      mem_addr_i = '0;
  logic [BE_W-1:0]  mem_be_i = '0;
  logic [MEM_W-1:0] mem_wdata_i = '0;
  logic             mem_rvalid_o;
  logic [MEM_W-1:0] mem_rdata_o;
  logic             mem_err_o;
  logic             sc_access_o;
  logic             sc_is_writing_o;
  logic [31:0]      sc_addr_o;
  logic [31:0]      sc_d_in_o;
  logic [BE_W-1:0]  sc_be_o;
  logic [31:0]      sc_d_out_i;
  logic             sc_out_valid_i;

  logic        ctl_vld = 1'b0;
  logic        stray_vld = 1'b0;
  logic [31:0] ctl_data = '0;
  int          ctl_delay = 0;

  // The controller returns data tied to the address so responses can be told apart.
  assign sc_out_valid_i = ctl_vld | stray_vld;
  assign sc_d_out_i     = ctl_data ^ sc_addr_o;

  vproc_mem_bridge #(
    .MEM_W(MEM_W),
    .FIFO_DEPTH(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req_i(mem_req_i),
    .mem_gnt_o(mem_gnt_o),
    .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i),
    .mem_be_i(mem_be_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rvalid_o(mem_rvalid_o),
    .mem_rdata_o(mem_rdata_o),
    .mem_err_o(mem_err_o),
    .sc_access_o(sc_access_o),
    .sc_is_writing_o(sc_is_writing_o),
    .sc_addr_o(sc_addr_o),
    .sc_d_in_o(sc_d_in_o),
    .sc_be_o(sc_be_o),
    .sc_d_out_i(sc_d_out_i),
    .sc_out_valid_i(sc_out_valid_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int rdata_viol = 0;
  int stab_viol = 0;

  logic [31:0]     rsp_data_q [$];
  logic            rsp_err_q  [$];
  int              rsp_cyc_q  [$];
  logic            cap_we;
  logic [31:0]     cap_addr, cap_din;
  logic [BE_W-1:0] cap_be;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rsp_data(input int i);
    return (rsp_data_q.size() > i) ? rsp_data_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] rsp_err(input int i);
    return (rsp_err_q.size() > i) ? 32'(rsp_err_q[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] rsp_lat(input int i, input int acc);
    return (rsp_cyc_q.size() > i) ? 32'(rsp_cyc_q[i] - acc) : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_rsp();
    rsp_data_q.delete();
    rsp_err_q.delete();
    rsp_cyc_q.delete();
  endtask

  task automatic stab_chk();
    if (sc_addr_o !== cap_addr || sc_be_o !== cap_be ||
        sc_is_writing_o !== cap_we || sc_d_in_o !== cap_din)
      stab_viol++;
  endtask

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_rvalid_o) begin
          rsp_data_q.push_back(mem_rdata_o);
          rsp_err_q.push_back(mem_err_o);
          rsp_cyc_q.push_back(cyc);
        end else if (mem_rdata_o !== '0) begin
          rdata_viol++;
        end
        if (sc_access_o) begin
          acc_cnt++;
          acc_cyc = cyc;
        end
      end
    end
  end

  // Storage controller model: completes ctl_delay cycles after the first WAIT cycle
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (rst && sc_access_o && ctl_delay >= 0) begin
        d        = ctl_delay;
        cap_we   = sc_is_writing_o;
        cap_addr = sc_addr_o;
        cap_be   = sc_be_o;
        cap_din  = sc_d_in_o;
        @(negedge clk);
        stab_chk();
        repeat (d) begin
          @(negedge clk);
          stab_chk();
        end
        ctl_vld = 1'b1;
        @(negedge clk);
        ctl_vld = 1'b0;
        stab_chk();
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [BE_W-1:0] be,
                      input logic [31:0] wd, output int acc);
    int k;
    k           = 0;
    acc         = -1;
    mem_req_i   = 1'b1;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_be_i    = be;
    mem_wdata_i = wd;
    while (acc < 0 && k < 50) begin
      if (mem_gnt_o) acc = cyc;
      @(negedge clk);
      k++;
    end
    mem_req_i = 1'b0;
    if (acc < 0) check_val("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k;
    k = 0;
    while (rsp_data_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_val("rsp_count", 32'(rsp_data_q.size()), 32'(n));
  endtask

  task automatic check_reset_outs(input string pfx);
    check_val({pfx, "_rvalid"}, 32'(mem_rvalid_o), 32'd0);
    check_val({pfx, "_err"}, 32'(mem_err_o), 32'd0);
    check_val({pfx, "_access"}, 32'(sc_access_o), 32'd0);
    check_val({pfx, "_writing"}, 32'(sc_is_writing_o), 32'd0);
    check_val({pfx, "_rdata"}, mem_rdata_o, 32'd0);
    check_val({pfx, "_addr"}, sc_addr_o, 32'd0);
    check_val({pfx, "_din"}, sc_d_in_o, 32'd0);
    check_val({pfx, "_be"}, 32'(sc_be_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2, n3, a0, tmp;

    repeat (3) @(negedge clk);
    check_reset_outs("rst0");
    rst = 1'b1;
    @(negedge clk);
    check_val("gnt_after_rst", 32'(mem_gnt_o), 32'd1);

    // Aligned read, controller answers in the first WAIT cycle
    ctl_delay = 0;
    ctl_data  = 32'hDEAD_BEEF ^ 32'h0000_0100;
    clear_rsp();
    a0 = acc_cnt;
    send(1'b0, 32'h0000_0100, 4'hF, 32'h0, n0);
    wait_rsp(1, 40);
    check_val("rd_data", rsp_data(0), 32'hDEAD_BEEF);
    check_val("rd_err", rsp_err(0), 32'd0);
    check_val("rd_latency", rsp_lat(0, n0), 32'd4);
    check_val("rd_access_cnt", 32'(acc_cnt - a0), 32'd1);
    check_val("rd_access_cyc", 32'(acc_cyc - n0), 32'd2);
    repeat (2) @(negedge clk);

    // Partial write, slow controller
    ctl_delay = 3;
    ctl_data  = 32'hFFFF_FFFF;
    clear_rsp();
    send(1'b1, 32'h0000_0040, 4'b0011, 32'h1234_5678, n0);
    wait_rsp(1, 40);
    check_val("wr_rdata", rsp_data(0), 32'd0);
    check_val("wr_err", rsp_err(0), 32'd0);
    check_val("wr_latency", rsp_lat(0, n0), 32'd7);
    check_val("wr_be", 32'(cap_be), 32'h3);
    check_val("wr_we", 32'(cap_we), 32'd1);
    check_val("wr_addr", cap_addr, 32'h0000_0040);
    check_val("wr_din", cap_din, 32'h1234_5678);
    repeat (2) @(negedge clk);

    // Misaligned read is rejected without touching the controller
    ctl_delay = 0;
    ctl_data  = 32'h5555_5555;
    clear_rsp();
    a0 = acc_cnt;
    send(1'b0, 32'h0000_0102, 4'hF, 32'h0, n0);
    wait_rsp(1, 40);
    check_val("ma_err", rsp_err(0), 32'd1);
    check_val("ma_rdata", rsp_data(0), 32'd0);
    check_val("ma_latency", rsp_lat(0, n0), 32'd2);
    check_val("ma_access_cnt", 32'(acc_cnt - a0), 32'd0);
    repeat (2) @(negedge clk);

    // Completion strobe while idle must be ignored
    clear_rsp();
    stray_vld = 1'b1;
    repeat (2) @(negedge clk);
    stray_vld = 1'b0;
    repeat (5) @(negedge clk);
    check_val("stray_no_rsp", 32'(rsp_data_q.size()), 32'd0);
    ctl_data = 32'hA5A5_0001;
    send(1'b0, 32'h0000_01F0, 4'hF, 32'h0, n0);
    wait_rsp(1, 40);
    check_val("post_stray_data", rsp_data(0), 32'hA5A5_0001 ^ 32'h0000_01F0);
    repeat (2) @(negedge clk);

    // Timeout: no completion within 16 WAIT cycles
    ctl_delay = -1;
    ctl_data  = 32'h0BAD_F00D;
    clear_rsp();
    send(1'b0, 32'h0001_0000, 4'hF, 32'h0, n0);
    wait_rsp(1, 60);
    check_val("to_err", rsp_err(0), 32'd1);
    check_val("to_rdata", rsp_data(0), 32'd0);
    check_val("to_latency", rsp_lat(0, n0), 32'd19);
    repeat (2) @(negedge clk);

    // Completion on the 16th WAIT cycle beats the timeout
    ctl_delay = 15;
    clear_rsp();
    send(1'b0, 32'h0001_0000, 4'hF, 32'h0, n0);
    wait_rsp(1, 60);
    check_val("late_err", rsp_err(0), 32'd0);
    check_val("late_data", rsp_data(0), 32'h0BAD_F00D ^ 32'h0001_0000);
    check_val("late_latency", rsp_lat(0, n0), 32'd19);
    repeat (2) @(negedge clk);

    // Back-pressure: three requests pile up behind a slow in-flight read
    ctl_delay = 4;
    ctl_data  = 32'h1111_0000;
    clear_rsp();
    send(1'b0, 32'h0000_0200, 4'hF, 32'h0, n0);
    repeat (2) @(negedge clk);
    send(1'b1, 32'h0000_0204, 4'hC, 32'hCAFE_0000, n1);
    send(1'b0, 32'h0000_0208, 4'hF, 32'h0, n2);
    send(1'b0, 32'h0000_020C, 4'hF, 32'h0, n3);
    check_val("bp_gnt1", 32'(n1 - n0), 32'd3);
    check_val("bp_gnt2", 32'(n2 - n1), 32'd1);
    check_val("bp_gnt3", 32'(n3 - n0), 32'd9);
    wait_rsp(4, 120);
    check_val("bp_rsp0", rsp_data(0), 32'h1111_0000 ^ 32'h0000_0200);
    check_val("bp_rsp1", rsp_data(1), 32'd0);
    check_val("bp_rsp2", rsp_data(2), 32'h1111_0000 ^ 32'h0000_0208);
    check_val("bp_rsp3", rsp_data(3), 32'h1111_0000 ^ 32'h0000_020C);
    tmp = 0;
    for (int i = 0; i < 4; i++) tmp += int'(rsp_err(i) != 32'd0);
    check_val("bp_errs", 32'(tmp), 32'd0);
    repeat (2) @(negedge clk);

    // Reset during WAIT with two requests queued
    ctl_delay = -1;
    clear_rsp();
    send(1'b0, 32'h0000_0300, 4'hF, 32'h0, n0);
    repeat (2) @(negedge clk);
    send(1'b1, 32'h0000_0304, 4'h1, 32'h0000_00AA, n1);
    send(1'b0, 32'h0000_0308, 4'hF, 32'h0, n2);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("rst_mid");
    rst = 1'b1;
    @(negedge clk);
    check_val("gnt_after_mid_rst", 32'(mem_gnt_o), 32'd1);
    repeat (30) @(negedge clk);
    check_val("mid_rst_no_rsp", 32'(rsp_data_q.size()), 32'd0);
    ctl_delay = 0;
    ctl_data  = 32'h7777_0000;
    send(1'b0, 32'h0000_0310, 4'hF, 32'h0, n0);
    wait_rsp(1, 40);
    check_val("post_rst_data", rsp_data(0), 32'h7777_0000 ^ 32'h0000_0310);
    check_val("post_rst_err", rsp_err(0), 32'd0);
    check_val("post_rst_latency", rsp_lat(0, n0), 32'd4);
    repeat (2) @(negedge clk);

    check_val("rdata_zero_when_idle", 32'(rdata_viol), 32'd0);
    check_val("sc_signals_stable", 32'(stab_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
